// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the two requester handshakes and the serial-line status of the
//   UART transmit arbiter into one interface.
//
//   Signals:
//     req0_valid / req0_data / req0_ready : requester 0 byte handshake
//     req1_valid / req1_data / req1_ready : requester 1 byte handshake
//     tx_out   : 8N1 serial line, idle high
//     busy     : a frame is in flight
//     grant_id : requester whose frame is in flight (or was last served)
//
//   Modports:
//     master : the requester side (drives valid/data, observes the rest)
//     slave  : the arbiter itself
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_out;
  logic       busy;
  logic       grant_id;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, tx_out, busy, grant_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, tx_out, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two requesters share one 8N1 UART transmitter. A round-robin arbiter
//   picks which requester is accepted while the transmitter is idle; the
//   accepted byte is sent as start bit, eight data bits LSB first, stop bit.
//
//   Parameters:
//     CLKS_PER_BIT : clk_in cycles per UART bit (>= 2)
//     CNT_W        : bit-period counter width, 2**CNT_W >= CLKS_PER_BIT
//
//   Ports:
//     clk_in : single clock, rising edge
//     rst    : asynchronous active-high reset; aborts any frame at once
//     bus    : uart_tx_arbiter_if.slave (handshakes, tx_out, busy, grant_id)
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic               clk_in,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             grant_reg, grant_next;
  logic             last_grant_reg, last_grant_next;

  logic             sel;
  logic             ready0;
  logic             ready1;
  logic             bit_done;

  // Requester selection: a lone requester wins outright; under contention
  // the one that was not served last wins. Ready is forced low during reset
  // so nothing is ever accepted while the block is being held.
  always_comb begin
    sel    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_reg : bus.req1_valid;
    ready0 = !rst && (state_reg == IDLE) && bus.req0_valid && !sel;
    ready1 = !rst && (state_reg == IDLE) && bus.req1_valid &&  sel;
  end

  assign bit_done = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = bit_done ? '0 : cnt_reg + CNT_W'(1);
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    tx_next         = tx_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        tx_next  = 1'b1;
        // The start bit is driven from the handshake edge itself so the
        // line falls on the first edge after acceptance.
        if (ready0) begin
          shift_next      = bus.req0_data;
          grant_next      = 1'b0;
          last_grant_next = 1'b0;
          state_next      = START;
          tx_next         = 1'b0;
        end else if (ready1) begin
          shift_next      = bus.req1_data;
          grant_next      = 1'b1;
          last_grant_next = 1'b1;
          state_next      = START;
          tx_next         = 1'b0;
        end
      end

      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift_reg[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            // Shift right so the next data bit always sits in bit 0.
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      tx_reg         <= 1'b1;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      tx_reg         <= tx_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.tx_out     = tx_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.grant_id   = grant_reg;

endmodule
